// File: rtl/arbitro_rr_vc.sv
// Round-robin arbiter over four virtual-channel FIFOs with bounded bursts.
// Pops at most one FIFO per cycle, forwards the popped head word through a
// registered output stage, and counts forwarded words.
//
// Ports:
//   clk, reset_L            : clock, asynchronous active-low reset
//   enable                  : 1 = arbitration permitted
//   empty[3:0]              : per-FIFO empty flags
//   data_in0..data_in3      : FIFO head words (valid while matching empty=0)
//   out_full                : downstream cannot accept a word this cycle
//   pop[3:0]                : combinational one-hot-or-zero pop strobe
//   data_out, select, valid : registered forwarded word, source channel, qualifier
//   contador                : words forwarded since reset, modulo 256
//   busy                    : 1 while the arbiter is in ACTIVE
module arbitro_rr_vc #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned BURST  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              out_full,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        select,
  output logic              valid,
  output logic [7:0]        contador,
  output logic              busy
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned BC_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   cur;
  logic [BC_W-1:0]   burst_cnt;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic              grant_ok;
  logic              keep;
  logic              any_word;
  logic              pop_any;
  logic [DATA_W-1:0] data_sel;

  assign any_word = (empty != {N_CH{1'b1}});
  assign pop_any  = |pop;

  // Channel choice. burst_cnt = 0 means no burst is in progress (after reset
  // or IDLE), so the grant rotates from cur instead of re-taking cur; this is
  // what makes cur=3 at reset hand the first grant to channel 0.
  always_comb begin
    keep      = (burst_cnt != '0) && (burst_cnt < BC_W'(BURST)) && !empty[cur];
    grant_idx = cur;
    grant_ok  = 1'b0;
    cand      = cur;
    if (keep) begin
      grant_ok = 1'b1;
    end else begin
      // k = 4 truncates to cur itself, the last candidate in the rotation
      for (int k = 1; k <= 4; k++) begin
        cand = cur + CH_W'(k);
        if (!grant_ok && !empty[cand]) begin
          grant_idx = cand;
          grant_ok  = 1'b1;
        end
      end
    end
  end

  // Head word of the granted channel
  always_comb begin
    data_sel = data_in0;
    case (grant_idx)
      2'd0:    data_sel = data_in0;
      2'd1:    data_sel = data_in1;
      2'd2:    data_sel = data_in2;
      default: data_sel = data_in3;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state. Only the empty flags are visible, so ACTIVE is left once
  // no channel reports a word. out_full takes priority over any pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && any_word) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!enable)        state_nxt = IDLE;
        else if (out_full)  state_nxt = STALL;
        else if (!any_word) state_nxt = IDLE;
      end
      STALL: begin
        if (!enable)        state_nxt = IDLE;
        else if (!out_full) state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: combinational pop strobe
  always_comb begin
    pop = '0;
    if ((state == ACTIVE) && !out_full && enable && any_word && grant_ok) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // Forwarding stage, arbitration pointer and counters
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cur       <= CH_W'(3);
      burst_cnt <= '0;
      data_out  <= '0;
      select    <= '0;
      valid     <= 1'b0;
      contador  <= '0;
      busy      <= 1'b0;
    end else begin
      busy  <= (state_nxt == ACTIVE);
      valid <= pop_any;
      if (pop_any) begin
        data_out  <= data_sel;
        select    <= grant_idx;
        contador  <= contador + CNT_W'(1);
        cur       <= grant_idx;
        burst_cnt <= keep ? burst_cnt + BC_W'(1) : BC_W'(1);
      end else if (state_nxt == IDLE) begin
        // cur is kept so rotation resumes where it left off
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_rr_vc.sv
// Directed bench for arbitro_rr_vc: behavioural FIFO models feed the four
// channels; expected pops and words are hand-computed per scenario.
module tb_arbitro_rr_vc;

  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          enable;
  logic [3:0]    empty;
  logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
  logic          out_full;
  logic [3:0]    pop;
  logic [DW-1:0] data_out;
  logic [1:0]    select;
  logic          valid;
  logic [7:0]    contador;
  logic          busy;

  int            cnt [4];
  int            head [4];
  logic          clr;
  logic [DW-1:0] dword [4];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arbitro_rr_vc #(.DATA_W(DW), .BURST(2)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .enable   (enable),
    .empty    (empty),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .out_full (out_full),
    .pop      (pop),
    .data_out (data_out),
    .select   (select),
    .valid    (valid),
    .contador (contador),
    .busy     (busy)
  );

  // Word stored at position h of FIFO c (FIFO1 -> 0x011, 0x012, ...)
  function automatic logic [DW-1:0] word(input int c, input int h);
    return DW'(c * 16 + 1 + h);
  endfunction

  // FIFO models: cnt words loaded, head advances on each pop
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (clr) head[i] <= 0;
      else if (pop[i]) head[i] <= head[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (head[i] >= cnt[i]);
      dword[i] = word(i, head[i]);
    end
  end

  assign data_in0 = dword[0];
  assign data_in1 = dword[1];
  assign data_in2 = dword[2];
  assign data_in3 = dword[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, clear FIFO models; returns just after a rising edge
  task automatic do_reset();
    reset_L  = 1'b0;
    enable   = 1'b0;
    out_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    do_reset();

    // Reset state
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_contador", 32'(contador), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur", 32'(dut.cur), 32'h3);

    // Single channel: FIFO1 holds 0x011..0x013
    cnt[1]  = 3;
    enable  = 1'b1;
    reset_L = 1'b1;
    #1;
    chk("single_no_pop_after_release", 32'(pop), 32'h0);
    tick();
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_pop0", 32'(pop), 32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("single_valid", 32'(valid), 32'h1);
      chk("single_data", 32'(data_out), 32'(word(1, k)));
      chk("single_select", 32'(select), 32'h1);
      chk("single_pop", 32'(pop), (k < 2) ? 32'h2 : 32'h0);
    end
    chk("single_contador", 32'(contador), 32'd3);
    tick();
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_valid", 32'(valid), 32'h0);
    chk("single_hold_data", 32'(data_out), 32'h013);
    chk("single_hold_select", 32'(select), 32'h1);

    // Burst rotation: all FIFOs hold 4 words -> 0,0,1,1,2,2,3,3,0,0,...
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 4;
    enable  = 1'b1;
    reset_L = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (k / 2) % 4;
      chk("rot_pop", 32'(pop), 32'(1) << c);
      tick();
      chk("rot_select", 32'(select), 32'(c));
      chk("rot_data", 32'(data_out), 32'(word(c, (k / 8) * 2 + k % 2)));
    end
    chk("rot_contador", 32'(contador), 32'd16);
    chk("rot_drained_pop", 32'(pop), 32'h0);

    // Stall mid-burst: three cycles of out_full after one word from FIFO0
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 4;
    enable  = 1'b1;
    reset_L = 1'b1;
    tick();
    chk("stall_first_pop", 32'(pop), 32'h1);
    tick();
    chk("stall_first_data", 32'(data_out), 32'(word(0, 0)));
    out_full = 1'b1;
    #1;
    chk("stall_pop_blocked", 32'(pop), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_state", 32'(dut.state), 32'h2);
      chk("stall_valid", 32'(valid), 32'h0);
      chk("stall_pop", 32'(pop), 32'h0);
    end
    out_full = 1'b0;
    #1;
    chk("stall_release_pop", 32'(pop), 32'h0);
    tick();
    chk("resume_valid", 32'(valid), 32'h0);
    chk("resume_pop", 32'(pop), 32'h1);
    tick();
    chk("resume_data", 32'(data_out), 32'(word(0, 1)));
    chk("resume_select", 32'(select), 32'h0);
    chk("resume_contador", 32'(contador), 32'd2);
    chk("resume_rotate_pop", 32'(pop), 32'h2);
    tick();
    chk("resume_next_data", 32'(data_out), 32'(word(1, 0)));

    // Empty skip: only FIFOs 0 and 2 hold words (empty = 4'b1010)
    do_reset();
    cnt[0]  = 4;
    cnt[2]  = 4;
    enable  = 1'b1;
    reset_L = 1'b1;
    #1;
    chk("skip_empty_flags", 32'(empty), 32'ha);
    tick();
    for (int k = 0; k < 8; k++) begin
      int c;
      c = ((k / 2) % 2) * 2;
      chk("skip_pop", 32'(pop), 32'(1) << c);
      tick();
      chk("skip_select", 32'(select), 32'(c));
      chk("skip_data", 32'(data_out), 32'(word(c, (k / 4) * 2 + k % 2)));
    end

    // Asynchronous reset mid-burst, between clock edges
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 4;
    enable  = 1'b1;
    reset_L = 1'b1;
    tick();
    tick();
    chk("areset_pre_contador", 32'(contador), 32'd1);
    reset_L = 1'b0;
    #1;
    chk("areset_valid", 32'(valid), 32'h0);
    chk("areset_data", 32'(data_out), 32'h0);
    chk("areset_select", 32'(select), 32'h0);
    chk("areset_contador", 32'(contador), 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_pop", 32'(pop), 32'h0);
    #1;
    reset_L = 1'b1;
    #1;
    chk("areset_release_pop", 32'(pop), 32'h0);
    tick();
    chk("areset_first_grant", 32'(pop), 32'h1);
    tick();
    chk("areset_first_data", 32'(data_out), 32'(word(0, 1)));
    chk("areset_contador_after", 32'(contador), 32'd1);

    // Counter wrap: 257 words from FIFO2
    do_reset();
    cnt[2]  = 257;
    enable  = 1'b1;
    reset_L = 1'b1;
    tick();
    repeat (256) tick();
    chk("wrap_256", 32'(contador), 32'd0);
    tick();
    chk("wrap_257", 32'(contador), 32'd1);
    chk("wrap_valid", 32'(valid), 32'h1);
    chk("wrap_data", 32'(data_out), 32'(word(2, 256)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
